// File: rtl/chess_pkg.sv
// Shared constants and types for the chess attack-array controllers.
// Holds search op codes, side encodings, piece codes and the sequencer FSM states.
package chess_pkg;

    localparam logic OP_VICTIM    = 1'b0;
    localparam logic OP_AGGRESSOR = 1'b1;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [2:0] {
        PC_NONE,
        PC_PAWN,
        PC_KNIGHT,
        PC_BISHOP,
        PC_ROOK,
        PC_QUEEN,
        PC_KING
    } piece_e;

    typedef enum logic [2:0] {
        IDLE,
        V_SETTLE,
        V_EVAL,
        A_SETTLE,
        A_EVAL,
        EMIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter covering the arbiter latency after a board control change.
// expired_o is high once LAT cycles have elapsed since the last load.
module settle_timer #(
    parameter int LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expired_o
);

    localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [TW-1:0] LOADV = (LAT > 0) ? TW'(LAT - 1) : '0;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOADV;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mvv_lva_sequencer.sv
// MVV-LVA move enumerator: best victim first, then its aggressors cheapest first.
// Drives the attack array controls and streams (from, to, prio) moves.
module mvv_lva_sequencer
    import chess_pkg::*;
#(
    parameter int SQ_BITS = 6,
    parameter int PRIO_W  = 3,
    parameter int ARB_LAT = 0,
    parameter int CNT_W   = 8,
    localparam int NSQ    = 1 << SQ_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               start_wtm,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               done_illegal,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [SQ_BITS-1:0] mv_from,
    output logic [SQ_BITS-1:0] mv_to,
    output logic [PRIO_W-1:0]  mv_prio,
    output logic [CNT_W-1:0]   mv_count,
    output logic               brd_op,
    output logic               brd_wtm,
    output logic [SQ_BITS-1:0] brd_xmit,
    output logic [NSQ-1:0]     brd_en,
    input  logic [NSQ-1:0]     brd_own,
    input  logic               brd_found,
    input  logic [SQ_BITS-1:0] brd_square,
    input  logic [PRIO_W-1:0]  brd_prio,
    input  logic               brd_illegal
);

    localparam seq_state_e V_NEXT = (ARB_LAT == 0) ? V_EVAL : V_SETTLE;
    localparam seq_state_e A_NEXT = (ARB_LAT == 0) ? A_EVAL : A_SETTLE;

    function automatic logic [NSQ-1:0] onehot(input logic [SQ_BITS-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    seq_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dill_q, dill_d;
    logic               mvv_q, mvv_d;
    logic [SQ_BITS-1:0] from_q, from_d;
    logic [SQ_BITS-1:0] to_q, to_d;
    logic [PRIO_W-1:0]  prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               wtm_q, wtm_d;
    logic [SQ_BITS-1:0] xmit_q, xmit_d;
    logic [NSQ-1:0]     en_q, en_d;
    logic [NSQ-1:0]     vmask_q, vmask_d;
    logic [NSQ-1:0]     amask_q, amask_d;
    logic [SQ_BITS-1:0] v_q, v_d;
    logic [PRIO_W-1:0]  vp_q, vp_d;
    logic               first_q, first_d;
    logic               tmr_load;
    logic               tmr_exp;

    // Arm the timer only on entry to a settle state, i.e. on a control change.
    assign tmr_load = (state_d != state_q) &&
                      ((state_d == V_SETTLE) || (state_d == A_SETTLE));

    settle_timer #(
        .LAT(ARB_LAT)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .expired_o(tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dill_d  = dill_q;
        mvv_d   = mvv_q;
        from_d  = from_q;
        to_d    = to_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wtm_d   = wtm_q;
        xmit_d  = xmit_q;
        en_d    = en_q;
        vmask_d = vmask_q;
        amask_d = amask_q;
        v_d     = v_q;
        vp_d    = vp_q;
        first_d = first_q;
        if ((state_q != IDLE) && abort) begin
            state_d = IDLE;
            mvv_d   = 1'b0;
            busy_d  = 1'b0;
            en_d    = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        wtm_d   = start_wtm;
                        op_d    = OP_VICTIM;
                        vmask_d = '1;
                        en_d    = '1;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        first_d = 1'b1;
                        dill_d  = 1'b0;
                        state_d = V_NEXT;
                    end
                end
                V_SETTLE: begin
                    if (tmr_exp) state_d = V_EVAL;
                end
                V_EVAL: begin
                    if (first_q && brd_illegal) begin
                        dill_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (!brd_found) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        v_d     = brd_square;
                        vp_d    = brd_prio;
                        amask_d = brd_own;
                        en_d    = brd_own;
                        op_d    = OP_AGGRESSOR;
                        xmit_d  = brd_square;
                        first_d = 1'b0;
                        state_d = A_NEXT;
                    end
                end
                A_SETTLE: begin
                    if (tmr_exp) state_d = A_EVAL;
                end
                A_EVAL: begin
                    if (brd_found) begin
                        from_d  = brd_square;
                        to_d    = v_q;
                        prio_d  = vp_q;
                        mvv_d   = 1'b1;
                        amask_d = amask_q & ~onehot(brd_square);
                        state_d = EMIT;
                    end else begin
                        vmask_d = vmask_q & ~onehot(v_q);
                        en_d    = vmask_q & ~onehot(v_q);
                        op_d    = OP_VICTIM;
                        state_d = V_NEXT;
                    end
                end
                EMIT: begin
                    if (mv_ready) begin
                        mvv_d   = 1'b0;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        en_d    = amask_q;
                        state_d = A_NEXT;
                    end
                end
                DONE: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dill_q  <= 1'b0;
            mvv_q   <= 1'b0;
            from_q  <= '0;
            to_q    <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_VICTIM;
            wtm_q   <= WHITE;
            xmit_q  <= '0;
            en_q    <= '1;
            vmask_q <= '1;
            amask_q <= '0;
            v_q     <= '0;
            vp_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dill_q  <= dill_d;
            mvv_q   <= mvv_d;
            from_q  <= from_d;
            to_q    <= to_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wtm_q   <= wtm_d;
            xmit_q  <= xmit_d;
            en_q    <= en_d;
            vmask_q <= vmask_d;
            amask_q <= amask_d;
            v_q     <= v_d;
            vp_q    <= vp_d;
            first_q <= first_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign done_illegal = dill_q;
    assign mv_valid     = mvv_q;
    assign mv_from      = from_q;
    assign mv_to        = to_q;
    assign mv_prio      = prio_q;
    assign mv_count     = cnt_q;
    assign brd_op       = op_q;
    assign brd_wtm      = wtm_q;
    assign brd_xmit     = xmit_q;
    assign brd_en       = en_q;

endmodule

// File: tb/tb_mvv_lva_sequencer.sv
// Directed bench: three sequencers (6-bit/lat0, 6-bit/lat3, 7-bit/lat0)
// each driven by a small scripted attack-array model.
module tb_mvv_lva_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic st [3];
    logic wtm_in [3];
    logic ab [3];
    logic rdy [3];
    logic bsy [3];
    logic dn [3];
    logic dil [3];
    logic mvv [3];
    logic [6:0] mfr [3];
    logic [6:0] mto [3];
    logic [2:0] mpr [3];
    logic [7:0] mcnt [3];
    logic bop [3];
    logic bwtm [3];
    logic [6:0] bx [3];
    logic [127:0] ben [3];
    logic [127:0] own [3];
    logic fnd [3];
    logic [6:0] bsq [3];
    logic [2:0] bpr [3];
    logic ill_o [3];

    int vsq [3];
    int vpr [3];
    int nv [3];
    int asq [3][2];
    int na [3];
    logic illcfg [3];
    int lat [3];
    int nsq [3];

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int SB = (k == 2) ? 7 : 6;
        localparam int LT = (k == 1) ? 3 : 0;
        localparam int NS = 1 << SB;
        logic [SB-1:0] from_w, to_w, xm_w;
        logic [NS-1:0] en_w;
        mvv_lva_sequencer #(
            .SQ_BITS(SB), .PRIO_W(3), .ARB_LAT(LT), .CNT_W(8)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (st[k]),
            .start_wtm   (wtm_in[k]),
            .abort       (ab[k]),
            .busy        (bsy[k]),
            .done        (dn[k]),
            .done_illegal(dil[k]),
            .mv_valid    (mvv[k]),
            .mv_ready    (rdy[k]),
            .mv_from     (from_w),
            .mv_to       (to_w),
            .mv_prio     (mpr[k]),
            .mv_count    (mcnt[k]),
            .brd_op      (bop[k]),
            .brd_wtm     (bwtm[k]),
            .brd_xmit    (xm_w),
            .brd_en      (en_w),
            .brd_own     (own[k][NS-1:0]),
            .brd_found   (fnd[k]),
            .brd_square  (bsq[k][SB-1:0]),
            .brd_prio    (bpr[k]),
            .brd_illegal (ill_o[k])
        );
        assign mfr[k] = 7'(from_w);
        assign mto[k] = 7'(to_w);
        assign bx[k]  = 7'(xm_w);
        assign ben[k] = 128'(en_w);
    end

    // Array model; results go stale for lat cycles after any control change.
    logic pop [3];
    logic pw [3];
    logic [6:0] px [3];
    logic [127:0] pen [3];
    int stale [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [127:0] o;
            logic chg;
            o = '0;
            for (int i = 0; i < na[k]; i++) o[asq[k][i]] = 1'b1;
            own[k] = o;
            chg = (bop[k] != pop[k]) || (bwtm[k] != pw[k]) ||
                  (bx[k] != px[k]) || (ben[k] != pen[k]);
            pop[k] = bop[k];
            pw[k]  = bwtm[k];
            px[k]  = bx[k];
            pen[k] = ben[k];
            if (chg && lat[k] > 0) stale[k] = lat[k];
            if (stale[k] > 0) begin
                fnd[k]   = 1'b1;
                bsq[k]   = 7'($urandom_range(0, nsq[k] - 1));
                bpr[k]   = 3'd7;
                ill_o[k] = 1'b1;
                stale[k] = stale[k] - 1;
            end else begin
                fnd[k]   = 1'b0;
                bsq[k]   = '0;
                bpr[k]   = '0;
                ill_o[k] = illcfg[k];
                if (!bop[k]) begin
                    if (nv[k] > 0 && ben[k][vsq[k]]) begin
                        fnd[k] = 1'b1;
                        bsq[k] = 7'(vsq[k]);
                        bpr[k] = 3'(vpr[k]);
                    end
                end else begin
                    for (int i = 0; i < na[k]; i++) begin
                        if (!fnd[k] && ben[k][asq[k][i]]) begin
                            fnd[k] = 1'b1;
                            bsq[k] = 7'(asq[k][i]);
                            bpr[k] = 3'd1;
                        end
                    end
                end
            end
        end
    end

    // Stream monitor and control snapshots.
    int nmv [3];
    int mvf [3][8];
    int mvt [3][8];
    int mvp [3][8];
    int vcnt [3];
    int cx [3];
    logic cxv [3];
    logic [127:0] cen [3];
    logic cenv [3];
    logic pop2 [3];
    int clr_req [3];
    int clr_ack [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clr_req[k] != clr_ack[k]) begin
                nmv[k]     = 0;
                vcnt[k]    = 0;
                cxv[k]     = 1'b0;
                cenv[k]    = 1'b0;
                clr_ack[k] = clr_req[k];
            end
            if (mvv[k]) vcnt[k] = vcnt[k] + 1;
            if (mvv[k] && rdy[k] && nmv[k] < 8) begin
                mvf[k][nmv[k]] = int'(mfr[k]);
                mvt[k][nmv[k]] = int'(mto[k]);
                mvp[k][nmv[k]] = int'(mpr[k]);
                nmv[k] = nmv[k] + 1;
            end
            if (bop[k] && !cxv[k]) begin
                cx[k]  = int'(bx[k]);
                cxv[k] = 1'b1;
            end
            if (pop2[k] && !bop[k] && !cenv[k]) begin
                cen[k]  = ben[k];
                cenv[k] = 1'b1;
            end
            pop2[k] = bop[k];
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int k, input int v, input int p,
                       input int a0, input int a1, input int n_a);
        vsq[k]    = v;
        vpr[k]    = p;
        nv[k]     = 1;
        asq[k][0] = a0;
        asq[k][1] = a1;
        na[k]     = n_a;
        clr_req[k] = clr_req[k] + 1;
    endtask

    task automatic go(input int k, input logic w);
        @(negedge clk);
        wtm_in[k] = w;
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output logic seen, output logic il);
        seen = 1'b0;
        il   = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (dn[k]) begin
                seen = 1'b1;
                il   = dil[k];
            end
        end
    endtask

    task automatic wait_valid(input int k, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (mvv[k]) seen = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic seen, il, ok, anyd;
        logic [127:0] ones64;
        ones64 = 128'(64'hFFFF_FFFF_FFFF_FFFF);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 0; wtm_in[k] = 0; ab[k] = 0; rdy[k] = 1;
            nv[k] = 0; na[k] = 0; illcfg[k] = 0; stale[k] = 0;
            vsq[k] = 0; vpr[k] = 0; asq[k][0] = 0; asq[k][1] = 0;
            clr_req[k] = 0;
        end
        lat[0] = 0; lat[1] = 3; lat[2] = 0;
        nsq[0] = 64; nsq[1] = 64; nsq[2] = 128;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_busy", 128'(bsy[0]), 0);
        check("rst_done", 128'(dn[0]), 0);
        check("rst_mvv", 128'(mvv[0]), 0);
        check("rst_cnt", 128'(mcnt[0]), 0);
        check("rst_from", 128'(mfr[0]), 0);
        check("rst_op", 128'(bop[0]), 0);
        check("rst_xmit", 128'(bx[0]), 0);
        check("rst_en", ben[0], ones64);
        check("rst_en128", ben[2], '1);

        // single victim 36 with one aggressor 12
        cfg(0, 36, 6, 12, 0, 1);
        go(0, 1'b0);
        wait_done(0, seen, il);
        check("t1_done", 128'(seen), 1);
        check("t1_illegal", 128'(il), 0);
        check("t1_nmv", 128'(nmv[0]), 1);
        check("t1_from", 128'(mvf[0][0]), 12);
        check("t1_to", 128'(mvt[0][0]), 36);
        check("t1_prio", 128'(mvp[0][0]), 6);
        check("t1_count", 128'(mcnt[0]), 1);
        check("t1_xmit", 128'(cx[0]), 36);
        check("t1_en36", 128'(cen[0][36]), 0);
        @(negedge clk);
        check("t1_busy", 128'(bsy[0]), 0);

        // illegal position on first victim search
        cfg(0, 36, 6, 12, 0, 1);
        illcfg[0] = 1'b1;
        go(0, 1'b0);
        @(negedge clk);
        check("t2_done", 128'(dn[0]), 1);
        check("t2_dill", 128'(dil[0]), 1);
        @(negedge clk);
        check("t2_novalid", 128'(vcnt[0]), 0);
        check("t2_dill_hold", 128'(dil[0]), 1);
        illcfg[0] = 1'b0;

        // two aggressors, consumer stalls the first move
        cfg(0, 20, 5, 3, 17, 2);
        rdy[0] = 1'b0;
        go(0, 1'b1);
        wait_valid(0, seen);
        check("t3_valid", 128'(seen), 1);
        check("t3_wtm", 128'(bwtm[0]), 1);
        check("t3_op", 128'(bop[0]), 1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (!(mvv[0] && mfr[0] == 7'd3)) ok = 1'b0;
        end
        check("t3_hold", 128'(ok), 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        check("t3_en3", 128'(ben[0][3]), 0);
        check("t3_en17", 128'(ben[0][17]), 1);
        wait_done(0, seen, il);
        check("t3_done", 128'(seen), 1);
        check("t3_dill", 128'(il), 0);
        check("t3_nmv", 128'(nmv[0]), 2);
        check("t3_from0", 128'(mvf[0][0]), 3);
        check("t3_from1", 128'(mvf[0][1]), 17);
        check("t3_to1", 128'(mvt[0][1]), 20);
        check("t3_count", 128'(mcnt[0]), 2);

        // abort during EMIT, then start+abort while idle, then restart
        cfg(0, 20, 5, 3, 17, 2);
        rdy[0] = 1'b0;
        go(0, 1'b0);
        wait_valid(0, seen);
        check("t5_valid", 128'(seen), 1);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        anyd = dn[0];
        check("t5_mvv", 128'(mvv[0]), 0);
        check("t5_busy", 128'(bsy[0]), 0);
        check("t5_en", ben[0], ones64);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            anyd = anyd | dn[0];
        end
        check("t5_nodone", 128'(anyd), 0);
        st[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        @(negedge clk);
        check("t5_sa_busy", 128'(bsy[0]), 0);
        cfg(0, 20, 5, 3, 17, 2);
        rdy[0] = 1'b1;
        go(0, 1'b0);
        wait_done(0, seen, il);
        check("t5_redone", 128'(seen), 1);
        check("t5_renmv", 128'(nmv[0]), 2);

        // pipelined array, ARB_LAT=3
        cfg(1, 36, 6, 12, 0, 1);
        go(1, 1'b0);
        wait_done(1, seen, il);
        check("t4_done", 128'(seen), 1);
        check("t4_illegal", 128'(il), 0);
        check("t4_nmv", 128'(nmv[1]), 1);
        check("t4_from", 128'(mvf[1][0]), 12);
        check("t4_to", 128'(mvt[1][0]), 36);
        check("t4_prio", 128'(mvp[1][0]), 6);
        check("t4_count", 128'(mcnt[1]), 1);

        // 128-square board
        cfg(2, 100, 4, 127, 0, 1);
        go(2, 1'b0);
        wait_done(2, seen, il);
        check("t6_done", 128'(seen), 1);
        check("t6_nmv", 128'(nmv[2]), 1);
        check("t6_from", 128'(mvf[2][0]), 127);
        check("t6_to", 128'(mvt[2][0]), 100);
        check("t6_en100", 128'(cen[2][100]), 0);
        check("t6_en99", 128'(cen[2][99]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mvv_lva_sequencer.md
Name: mvv_lva_sequencer

Overview:
- Autonomous move-enumeration controller for the chess attack array. Replaces host-driven FIND-VICTIM / FIND-AGGRESSOR command sequences.
- Owns the search controls: op, side to move, transmit square and a full per-square enable mask.
- Runs an MVV-LVA loop: find the most valuable enabled victim, then each aggressor of that victim in least-valuable-first order. Each (from, to, priority) move is emitted on a valid/ready stream.
- Parametrised in board size and arbiter latency, so it also drives pipelined or larger arrays.

Parameters:
- SQ_BITS, 6, square index width; NSQ = 2**SQ_BITS squares.
- PRIO_W, 3, width of arbiter priority.
- ARB_LAT, 0, cycles between a control change and a valid arbiter result (0 = combinational array).
- CNT_W, 8, width of emitted-move counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a search when idle
- start_wtm  in  1  side to move for this search (0 white, 1 black)
- abort  in  1  pulse; abandon the search
- busy  out  1  high from accepted start until DONE/IDLE
- done  out  1  one-cycle pulse at search end
- done_illegal  out  1  valid with done: side not to move is in check (position illegal)
- mv_valid  out  1  move available
- mv_ready  in  1  consumer accepts move
- mv_from  out  SQ_BITS  aggressor square
- mv_to  out  SQ_BITS  victim square
- mv_prio  out  PRIO_W  victim priority (higher = more valuable)
- mv_count  out  CNT_W  moves emitted this search
- brd_op  out  1  0 victim search, 1 aggressor search
- brd_wtm  out  1  side to move driven to the array
- brd_xmit  out  SQ_BITS  transmitter square for aggressor search
- brd_en  out  NSQ  per-square enable mask
- brd_own  in  NSQ  occupancy mask of the side to move
- brd_found  in  1  arbiter found a square with nonzero priority
- brd_square  in  SQ_BITS  winning square
- brd_prio  in  PRIO_W  winning priority
- brd_illegal  in  1  array illegal flag

Behaviour:
- Reset values:
  - state IDLE; busy, done, done_illegal, mv_valid all 0.
  - mv_from, mv_to, mv_prio, mv_count all 0.
  - brd_op 0, brd_wtm 0, brd_xmit 0, brd_en all ones.
- All brd_* outputs are registered. A "control change" is any edge that updates brd_op, brd_wtm, brd_xmit or brd_en.
- SETTLE rule:
  - After a control change, the FSM spends ARB_LAT cycles in the matching *_SETTLE state, then samples brd_* inputs in *_EVAL.
  - With ARB_LAT=0, *_SETTLE is skipped and EVAL is the cycle after the change.
- States:
  - IDLE:
    - start: latch start_wtm to brd_wtm, brd_op<=0, victim_mask<=all ones, brd_en<=all ones, mv_count<=0, busy<=1, first<=1 -> V_SETTLE.
    - start while busy is ignored.
  - V_EVAL:
    - if first and brd_illegal -> DONE with done_illegal=1.
    - else if !brd_found -> DONE.
    - else: v<=brd_square, vp<=brd_prio, aggr_mask<=brd_own, brd_en<=brd_own, brd_op<=1, brd_xmit<=brd_square, first<=0 -> A_SETTLE.
  - A_EVAL:
    - brd_found: mv_from<=brd_square, mv_to<=v, mv_prio<=vp, mv_valid<=1, aggr_mask[brd_square]<=0 -> EMIT.
    - !brd_found: victim_mask[v]<=0, brd_en<=victim_mask with bit v cleared, brd_op<=0 -> V_SETTLE.
  - EMIT:
    - hold mv_* stable while mv_valid && !mv_ready.
    - on handshake: mv_valid<=0, mv_count<=mv_count+1 (saturating at all ones), brd_en<=aggr_mask -> A_SETTLE.
  - DONE: done<=1 for one cycle, busy<=0 -> IDLE. done_illegal is held until the next start.
- abort: in any non-IDLE state, next state IDLE, mv_valid<=0, busy<=0, no done pulse, brd_en<=all ones. abort has priority over every other transition. abort in IDLE has no effect.
- start and abort in the same cycle while IDLE: abort wins; no search begins.
- mv_valid never drops without a handshake except on abort or reset.
- Reset mid-search behaves exactly like abort plus the full reset values.
- Termination: each victim is visited once and each aggressor at most once per victim, so the search ends after at most NSQ*(NSQ+1) EVALs.
- The square index used to clear masks is taken modulo NSQ. brd_square is trusted to be < NSQ.

Decomposition:
- Shared package chess_pkg holds:
  - OP_VICTIM/OP_AGGRESSOR and WHITE/BLACK constants.
  - Piece codes.
  - FSM state enum (IDLE, V_SETTLE, V_EVAL, A_SETTLE, A_EVAL, EMIT, DONE).
- One natural sub-module: settle_timer, an ARB_LAT down-counter with load/expire. Mask registers and the FSM stay in the top module.

Test Plan:
1. Scripted board, ARB_LAT=0, start_wtm=0; victim search returns found sq 36 prio 6, then aggressor searches return 12, then 0; victim search then returns none.
   -> one move from 12, to 36, prio 6, mv_count=1.
   -> brd_xmit=36 during the aggressor phase; brd_en bit 36 cleared on return to the victim phase; done pulse, done_illegal=0.
2. First V_EVAL sees brd_illegal=1 -> done and done_illegal=1 two cycles after start, mv_valid never asserted.
3. Two aggressors 3 and 17 for one victim, mv_ready held low 5 cycles on the first move.
   -> mv_from=3 stable for 5 cycles, then mv_from=17.
   -> brd_en bit 3 cleared before the second A_EVAL.
4. ARB_LAT=3: after every control change the board result is X for 3 cycles.
   -> no EVAL samples during those cycles; same move list as test 1.
5. abort asserted while in EMIT with mv_valid=1 -> next cycle mv_valid=0, busy=0, brd_en all ones, no done pulse; a following start works normally.
6. SQ_BITS=7 (128 squares), victim at sq 100, aggressor at sq 127 -> mv_from=127, mv_to=100; bit 100 cleared in the victim mask afterwards.
